// File: rtl/arb_pkg.sv
// Shared constants and the tie-break helper for the two-requester AXI4-Lite arbiter.
package arb_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WR   = 2'd1;
    localparam logic [1:0] ST_RD   = 2'd2;

    localparam logic REQ_CORE = 1'b0;
    localparam logic REQ_AUX  = 1'b1;

    localparam logic [31:0] ARB_ERR_DATA = 32'hDEAD_BEEF;

    // A lone requester always wins; on a tie the one that did not own the last transaction wins.
    function automatic logic pick_winner(input logic req_core, input logic req_aux, input logic last_grant);
        logic win;
        if (req_core && req_aux) begin
            win = ~last_grant;
        end else if (req_aux) begin
            win = REQ_AUX;
        end else begin
            win = REQ_CORE;
        end
        return win;
    endfunction

endpackage

// File: rtl/arb_watchdog.sv
// Saturating per-transaction cycle counter; flags expiry while a transaction is open.
module arb_watchdog #(
    parameter int CNT_W          = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_r;

    // Count cycles spent in a transaction, restarting on every state entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (run && (cnt_r != LIMIT)) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expired = run & (cnt_r == LIMIT);

endmodule

// File: rtl/axi_lite_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite master port between two requesters, one whole transaction at a time.
// Optional watchdog with forced error response: define ARB_TIMEOUT_EN.
module axi_lite_arbiter
    import arb_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] m0_AWdata,
    input  logic [DATA_W-1:0] m0_ARdata,
    input  logic [DATA_W-1:0] m0_Wdata,
    input  logic [3:0]        m0_Wstrb,
    input  logic [2:0]        m0_AWprot,
    input  logic [2:0]        m0_ARprot,
    input  logic              m0_AWvalid,
    input  logic              m0_Wvalid,
    input  logic              m0_ARvalid,
    input  logic              m0_Bready,
    input  logic              m0_Rready,
    output logic              m0_AWready,
    output logic              m0_Wready,
    output logic              m0_ARready,
    output logic              m0_Bvalid,
    output logic              m0_Rvalid,
    output logic [DATA_W-1:0] m0_Rdata,
    input  logic [DATA_W-1:0] m1_AWdata,
    input  logic [DATA_W-1:0] m1_ARdata,
    input  logic [DATA_W-1:0] m1_Wdata,
    input  logic [3:0]        m1_Wstrb,
    input  logic [2:0]        m1_AWprot,
    input  logic [2:0]        m1_ARprot,
    input  logic              m1_AWvalid,
    input  logic              m1_Wvalid,
    input  logic              m1_ARvalid,
    input  logic              m1_Bready,
    input  logic              m1_Rready,
    output logic              m1_AWready,
    output logic              m1_Wready,
    output logic              m1_ARready,
    output logic              m1_Bvalid,
    output logic              m1_Rvalid,
    output logic [DATA_W-1:0] m1_Rdata,
    output logic [DATA_W-1:0] s_AWdata,
    output logic [DATA_W-1:0] s_ARdata,
    output logic [DATA_W-1:0] s_Wdata,
    output logic [3:0]        s_Wstrb,
    output logic [2:0]        s_AWprot,
    output logic [2:0]        s_ARprot,
    output logic              s_AWvalid,
    output logic              s_Wvalid,
    output logic              s_ARvalid,
    output logic              s_Bready,
    output logic              s_Rready,
    input  logic              s_AWready,
    input  logic              s_Wready,
    input  logic              s_ARready,
    input  logic              s_Bvalid,
    input  logic              s_Rvalid,
    input  logic [DATA_W-1:0] s_Rdata,
    output logic              grant,
    output logic              busy
`ifdef ARB_TIMEOUT_EN
    ,
    output logic              timeout_err
`endif
);

    logic [1:0]        state_r, next_state_s;
    logic              grant_r, busy_r, last_grant_r;
    logic              aw_done_r, w_done_r, ar_done_r;
    logic              req0_s, req1_s, win_s, tmo_s, sel0_s, sel1_s;
    logic              aw_hs_s, w_hs_s, ar_hs_s, b_hs_s, r_hs_s;
    logic [DATA_W-1:0] mg_awdata_s, mg_ardata_s, mg_wdata_s;
    logic [3:0]        mg_wstrb_s;
    logic [2:0]        mg_awprot_s, mg_arprot_s;
    logic              mg_awvalid_s, mg_wvalid_s, mg_arvalid_s, mg_bready_s, mg_rready_s;
    logic              g_awready_s, g_wready_s, g_arready_s, g_bvalid_s, g_rvalid_s;
    logic [DATA_W-1:0] g_rdata_s;

    // A held AWvalid makes the requester's read wait, so write wins within one requester.
    assign req0_s  = m0_AWvalid | m0_ARvalid;
    assign req1_s  = m1_AWvalid | m1_ARvalid;
    assign win_s   = pick_winner(req0_s, req1_s, last_grant_r);
    assign aw_hs_s = s_AWvalid & s_AWready;
    assign w_hs_s  = s_Wvalid & s_Wready;
    assign ar_hs_s = s_ARvalid & s_ARready;
    assign b_hs_s  = s_Bvalid & s_Bready;
    assign r_hs_s  = s_Rvalid & s_Rready;

`ifdef ARB_TIMEOUT_EN
    arb_watchdog #(
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (next_state_s != state_r),
        .run     (state_r != ST_IDLE),
        .expired (tmo_s)
    );

    // One-cycle error pulse when a timed-out transaction is retired.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= tmo_s & (next_state_s == ST_IDLE);
        end
    end
`else
    assign tmo_s = 1'b0;
`endif

    // Select the granted requester's request-side signals.
    always_comb begin
        if (grant_r == REQ_AUX) begin
            mg_awdata_s  = m1_AWdata;  mg_ardata_s  = m1_ARdata;  mg_wdata_s  = m1_Wdata;
            mg_wstrb_s   = m1_Wstrb;   mg_awprot_s  = m1_AWprot;  mg_arprot_s = m1_ARprot;
            mg_awvalid_s = m1_AWvalid; mg_wvalid_s  = m1_Wvalid;  mg_arvalid_s = m1_ARvalid;
            mg_bready_s  = m1_Bready;  mg_rready_s  = m1_Rready;
        end else begin
            mg_awdata_s  = m0_AWdata;  mg_ardata_s  = m0_ARdata;  mg_wdata_s  = m0_Wdata;
            mg_wstrb_s   = m0_Wstrb;   mg_awprot_s  = m0_AWprot;  mg_arprot_s = m0_ARprot;
            mg_awvalid_s = m0_AWvalid; mg_wvalid_s  = m0_Wvalid;  mg_arvalid_s = m0_ARvalid;
            mg_bready_s  = m0_Bready;  mg_rready_s  = m0_Rready;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic: a transaction closes on its response handshake (or on a forced response).
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req0_s || req1_s) begin
                    if (win_s ? m1_AWvalid : m0_AWvalid) begin
                        next_state_s = ST_WR;
                    end else begin
                        next_state_s = ST_RD;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_WR: begin
                if (b_hs_s || (tmo_s && mg_bready_s)) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_WR;
                end
            end
            ST_RD: begin
                if (r_hs_s || (tmo_s && mg_rready_s)) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_RD;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Output logic: downstream port and the granted requester's responses; everything quiet in IDLE.
    always_comb begin
        s_AWdata    = {DATA_W{1'b0}}; s_ARdata  = {DATA_W{1'b0}}; s_Wdata   = {DATA_W{1'b0}};
        s_Wstrb     = 4'd0;           s_AWprot  = 3'd0;           s_ARprot  = 3'd0;
        s_AWvalid   = 1'b0; s_Wvalid  = 1'b0; s_ARvalid  = 1'b0; s_Bready   = 1'b0; s_Rready = 1'b0;
        g_awready_s = 1'b0; g_wready_s = 1'b0; g_arready_s = 1'b0; g_bvalid_s = 1'b0; g_rvalid_s = 1'b0;
        g_rdata_s   = {DATA_W{1'b0}};
        case (state_r)
            ST_WR: begin
                s_AWdata    = mg_awdata_s;
                s_AWprot    = mg_awprot_s;
                s_Wdata     = mg_wdata_s;
                s_Wstrb     = mg_wstrb_s;
                s_AWvalid   = mg_awvalid_s & ~aw_done_r & ~tmo_s;
                s_Wvalid    = mg_wvalid_s & ~w_done_r & ~tmo_s;
                s_Bready    = mg_bready_s & ~tmo_s;
                g_awready_s = s_AWready & ~aw_done_r & ~tmo_s;
                g_wready_s  = s_Wready & ~w_done_r & ~tmo_s;
                g_bvalid_s  = s_Bvalid | tmo_s;
            end
            ST_RD: begin
                s_ARdata    = mg_ardata_s;
                s_ARprot    = mg_arprot_s;
                s_ARvalid   = mg_arvalid_s & ~ar_done_r & ~tmo_s;
                s_Rready    = mg_rready_s & ~tmo_s;
                g_arready_s = s_ARready & ~ar_done_r & ~tmo_s;
                g_rvalid_s  = s_Rvalid | tmo_s;
                g_rdata_s   = tmo_s ? DATA_W'(ARB_ERR_DATA) : s_Rdata;
            end
            default: begin
            end
        endcase
    end

    assign sel0_s = busy_r & (grant_r == REQ_CORE);
    assign sel1_s = busy_r & (grant_r == REQ_AUX);

    assign m0_AWready = sel0_s & g_awready_s;
    assign m0_Wready  = sel0_s & g_wready_s;
    assign m0_ARready = sel0_s & g_arready_s;
    assign m0_Bvalid  = sel0_s & g_bvalid_s;
    assign m0_Rvalid  = sel0_s & g_rvalid_s;
    assign m0_Rdata   = sel0_s ? g_rdata_s : {DATA_W{1'b0}};
    assign m1_AWready = sel1_s & g_awready_s;
    assign m1_Wready  = sel1_s & g_wready_s;
    assign m1_ARready = sel1_s & g_arready_s;
    assign m1_Bvalid  = sel1_s & g_bvalid_s;
    assign m1_Rvalid  = sel1_s & g_rvalid_s;
    assign m1_Rdata   = sel1_s ? g_rdata_s : {DATA_W{1'b0}};
    assign grant      = grant_r;
    assign busy       = busy_r;

    // Ownership: latch the winner on arbitration, remember it for round-robin when the transaction closes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_r      <= REQ_CORE;
            busy_r       <= 1'b0;
            last_grant_r <= REQ_AUX;
        end else if ((state_r == ST_IDLE) && (next_state_s != ST_IDLE)) begin
            grant_r <= win_s;
            busy_r  <= 1'b1;
        end else if ((state_r != ST_IDLE) && (next_state_s == ST_IDLE)) begin
            busy_r       <= 1'b0;
            last_grant_r <= grant_r;
        end else begin
            busy_r <= busy_r;
        end
    end

    // Per-channel completion flags so each address/data beat is forwarded exactly once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
            ar_done_r <= 1'b0;
        end else if (next_state_s == ST_IDLE) begin
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
            ar_done_r <= 1'b0;
        end else begin
            aw_done_r <= aw_done_r | aw_hs_s;
            w_done_r  <= w_done_r | w_hs_s;
            ar_done_r <= ar_done_r | ar_hs_s;
        end
    end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed self-checking bench for axi_lite_arbiter; the timeout scenario is built with ARB_TIMEOUT_EN.
module tb_axi_lite_arbiter;

    localparam int DATA_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [DATA_W-1:0] m0_AWdata, m0_ARdata, m0_Wdata, m1_AWdata, m1_ARdata, m1_Wdata;
    logic [3:0]        m0_Wstrb, m1_Wstrb;
    logic [2:0]        m0_AWprot, m0_ARprot, m1_AWprot, m1_ARprot;
    logic              m0_AWvalid, m0_Wvalid, m0_ARvalid, m0_Bready, m0_Rready;
    logic              m1_AWvalid, m1_Wvalid, m1_ARvalid, m1_Bready, m1_Rready;
    logic              m0_AWready, m0_Wready, m0_ARready, m0_Bvalid, m0_Rvalid;
    logic              m1_AWready, m1_Wready, m1_ARready, m1_Bvalid, m1_Rvalid;
    logic [DATA_W-1:0] m0_Rdata, m1_Rdata;
    logic [DATA_W-1:0] s_AWdata, s_ARdata, s_Wdata, s_Rdata;
    logic [3:0]        s_Wstrb;
    logic [2:0]        s_AWprot, s_ARprot;
    logic              s_AWvalid, s_Wvalid, s_ARvalid, s_Bready, s_Rready;
    logic              s_AWready, s_Wready, s_ARready, s_Bvalid, s_Rvalid;
    logic              grant, busy;
`ifdef ARB_TIMEOUT_EN
    logic              timeout_err;
`endif

    logic [186:0] all_outs;
    assign all_outs = {m0_AWready, m0_Wready, m0_ARready, m0_Bvalid, m0_Rvalid, m0_Rdata,
                       m1_AWready, m1_Wready, m1_ARready, m1_Bvalid, m1_Rvalid, m1_Rdata,
                       s_AWdata, s_ARdata, s_Wdata, s_Wstrb, s_AWprot, s_ARprot,
                       s_AWvalid, s_Wvalid, s_ARvalid, s_Bready, s_Rready, grant, busy};

    int tests = 0;
    int fails = 0;

    axi_lite_arbiter #(.DATA_W(DATA_W), .TIMEOUT_CYCLES(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .m0_AWdata(m0_AWdata), .m0_ARdata(m0_ARdata), .m0_Wdata(m0_Wdata), .m0_Wstrb(m0_Wstrb),
        .m0_AWprot(m0_AWprot), .m0_ARprot(m0_ARprot), .m0_AWvalid(m0_AWvalid), .m0_Wvalid(m0_Wvalid),
        .m0_ARvalid(m0_ARvalid), .m0_Bready(m0_Bready), .m0_Rready(m0_Rready),
        .m0_AWready(m0_AWready), .m0_Wready(m0_Wready), .m0_ARready(m0_ARready),
        .m0_Bvalid(m0_Bvalid), .m0_Rvalid(m0_Rvalid), .m0_Rdata(m0_Rdata),
        .m1_AWdata(m1_AWdata), .m1_ARdata(m1_ARdata), .m1_Wdata(m1_Wdata), .m1_Wstrb(m1_Wstrb),
        .m1_AWprot(m1_AWprot), .m1_ARprot(m1_ARprot), .m1_AWvalid(m1_AWvalid), .m1_Wvalid(m1_Wvalid),
        .m1_ARvalid(m1_ARvalid), .m1_Bready(m1_Bready), .m1_Rready(m1_Rready),
        .m1_AWready(m1_AWready), .m1_Wready(m1_Wready), .m1_ARready(m1_ARready),
        .m1_Bvalid(m1_Bvalid), .m1_Rvalid(m1_Rvalid), .m1_Rdata(m1_Rdata),
        .s_AWdata(s_AWdata), .s_ARdata(s_ARdata), .s_Wdata(s_Wdata), .s_Wstrb(s_Wstrb),
        .s_AWprot(s_AWprot), .s_ARprot(s_ARprot), .s_AWvalid(s_AWvalid), .s_Wvalid(s_Wvalid),
        .s_ARvalid(s_ARvalid), .s_Bready(s_Bready), .s_Rready(s_Rready),
        .s_AWready(s_AWready), .s_Wready(s_Wready), .s_ARready(s_ARready),
        .s_Bvalid(s_Bvalid), .s_Rvalid(s_Rvalid), .s_Rdata(s_Rdata),
        .grant(grant), .busy(busy)
`ifdef ARB_TIMEOUT_EN
        , .timeout_err(timeout_err)
`endif
    );

    task automatic clear_inputs();
        m0_AWdata = 32'd0; m0_ARdata = 32'd0; m0_Wdata = 32'd0; m0_Wstrb = 4'd0;
        m0_AWprot = 3'd0;  m0_ARprot = 3'd0;
        m0_AWvalid = 1'b0; m0_Wvalid = 1'b0; m0_ARvalid = 1'b0; m0_Bready = 1'b0; m0_Rready = 1'b0;
        m1_AWdata = 32'd0; m1_ARdata = 32'd0; m1_Wdata = 32'd0; m1_Wstrb = 4'd0;
        m1_AWprot = 3'd0;  m1_ARprot = 3'd0;
        m1_AWvalid = 1'b0; m1_Wvalid = 1'b0; m1_ARvalid = 1'b0; m1_Bready = 1'b0; m1_Rready = 1'b0;
        s_AWready = 1'b0; s_Wready = 1'b0; s_ARready = 1'b0; s_Bvalid = 1'b0; s_Rvalid = 1'b0;
        s_Rdata = 32'd0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        clear_inputs();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        @(negedge clk);
        tests++;
        if (all_outs !== 187'd0) begin
            fails++; $display("FAIL reset_outputs: got %h want 0", all_outs);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if ({busy, grant} !== 2'b00 || all_outs !== 187'd0) begin
            fails++; $display("FAIL reset_idle: busy=%b grant=%b outs=%h want all 0", busy, grant, all_outs);
        end
    endtask

    task automatic test_read_m0();
        @(posedge clk); #1;
        m0_ARvalid = 1'b1; m0_ARdata = 32'h0000_0100; m0_ARprot = 3'd2; m0_Rready = 1'b1;
        @(negedge clk);
        tests++;
        if ({s_ARvalid, busy, m0_ARready} !== 3'b000) begin
            fails++; $display("FAIL rd_no_passthrough: s_ARvalid=%b busy=%b ARready=%b want 000", s_ARvalid, busy, m0_ARready);
        end
        @(posedge clk); #1;
        @(negedge clk);
        tests++;
        if ({busy, grant, s_ARvalid} !== 3'b101 || s_ARdata !== 32'h0000_0100 || s_ARprot !== 3'd2) begin
            fails++; $display("FAIL rd_grant: busy=%b grant=%b ARvalid=%b ARdata=%h prot=%0d want 1 0 1 100 2", busy, grant, s_ARvalid, s_ARdata, s_ARprot);
        end
        s_ARready = 1'b1;
        #1;
        tests++;
        if ({m0_ARready, m1_ARready} !== 2'b10) begin
            fails++; $display("FAIL rd_arready_route: m0=%b m1=%b want 10", m0_ARready, m1_ARready);
        end
        @(posedge clk); #1;
        m0_ARvalid = 1'b0; s_ARready = 1'b0; s_Rvalid = 1'b1; s_Rdata = 32'hCAFE_0001;
        @(negedge clk);
        tests++;
        if ({m0_Rvalid, m1_Rvalid, s_Rready, s_ARvalid} !== 4'b1010 || m0_Rdata !== 32'hCAFE_0001 || m1_Rdata !== 32'd0) begin
            fails++; $display("FAIL rd_data: m0_Rvalid=%b m1_Rvalid=%b Rready=%b ARvalid=%b Rdata=%h want 1 0 1 0 cafe0001", m0_Rvalid, m1_Rvalid, s_Rready, s_ARvalid, m0_Rdata);
        end
        @(posedge clk); #1;
        s_Rvalid = 1'b0; m0_Rready = 1'b0;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || all_outs !== 187'd0) begin
            fails++; $display("FAIL rd_idle: busy=%b outs=%h want 0", busy, all_outs);
        end
    endtask

    task automatic test_write_both();
        do_reset();
        m0_AWvalid = 1'b1; m0_AWdata = 32'h0000_0200; m0_Wvalid = 1'b1; m0_Wdata = 32'h1111_1111;
        m0_Wstrb = 4'hF; m0_Bready = 1'b1;
        m1_AWvalid = 1'b1; m1_AWdata = 32'h0000_0300; m1_Wvalid = 1'b1; m1_Wdata = 32'h2222_2222;
        m1_Wstrb = 4'h3; m1_Bready = 1'b1;
        s_AWready = 1'b1; s_Wready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        tests++;
        if ({busy, grant} !== 2'b10 || s_AWdata !== 32'h0000_0200 || s_Wdata !== 32'h1111_1111 || s_Wstrb !== 4'hF) begin
            fails++; $display("FAIL wr_tie_m0: busy=%b grant=%b AW=%h W=%h strb=%h want 1 0 200 11111111 f", busy, grant, s_AWdata, s_Wdata, s_Wstrb);
        end
        tests++;
        if ({m0_AWready, m0_Wready, m1_AWready, m1_Wready, m1_Bvalid} !== 5'b11000) begin
            fails++; $display("FAIL wr_ready_route: got %b want 11000", {m0_AWready, m0_Wready, m1_AWready, m1_Wready, m1_Bvalid});
        end
        @(posedge clk); #1;
        m0_AWvalid = 1'b0; m0_Wvalid = 1'b0; s_Bvalid = 1'b1;
        @(negedge clk);
        tests++;
        if ({m0_Bvalid, m1_Bvalid, s_Bready, s_AWvalid, s_Wvalid, m1_AWready} !== 6'b101000) begin
            fails++; $display("FAIL wr_b_m0: got %b want 101000", {m0_Bvalid, m1_Bvalid, s_Bready, s_AWvalid, s_Wvalid, m1_AWready});
        end
        @(posedge clk); #1;
        s_Bvalid = 1'b0;
        @(negedge clk);
        tests++;
        if ({busy, s_AWvalid, m1_AWready} !== 3'b000) begin
            fails++; $display("FAIL wr_idle_gap: busy=%b AWvalid=%b m1_AWready=%b want 000", busy, s_AWvalid, m1_AWready);
        end
        @(posedge clk); #1;
        @(negedge clk);
        tests++;
        if ({busy, grant} !== 2'b11 || s_AWdata !== 32'h0000_0300 || s_Wdata !== 32'h2222_2222 || {m0_AWready, m1_AWready} !== 2'b01) begin
            fails++; $display("FAIL wr_m1_second: busy=%b grant=%b AW=%h W=%h rdy=%b want 1 1 300 22222222 01", busy, grant, s_AWdata, s_Wdata, {m0_AWready, m1_AWready});
        end
        @(posedge clk); #1;
        m1_AWvalid = 1'b0; m1_Wvalid = 1'b0; s_Bvalid = 1'b1;
        @(negedge clk);
        tests++;
        if ({m0_Bvalid, m1_Bvalid} !== 2'b01) begin
            fails++; $display("FAIL wr_b_m1: m0=%b m1=%b want 01", m0_Bvalid, m1_Bvalid);
        end
        @(posedge clk); #1;
        s_Bvalid = 1'b0; s_AWready = 1'b0; s_Wready = 1'b0; m0_Bready = 1'b0; m1_Bready = 1'b0;
    endtask

    task automatic test_w_before_aw();
        int wcnt = 0;
        int awcnt = 0;
        int rdycnt = 0;
        m1_AWvalid = 1'b1; m1_AWdata = 32'h0000_0400; m1_Wvalid = 1'b1; m1_Wdata = 32'h3333_3333;
        m1_Wstrb = 4'hC; m1_Bready = 1'b1; m0_Bready = 1'b1;
        s_AWready = 1'b0; s_Wready = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 3) s_AWready = 1'b1;
            #1;
            if (s_Wvalid && s_Wready) wcnt++;
            if (s_AWvalid && s_AWready) awcnt++;
            if (m1_Wready) rdycnt++;
            @(posedge clk); #1;
            s_AWready = 1'b0;
        end
        s_Bvalid = 1'b1;
        @(negedge clk);
        if (s_Wvalid && s_Wready) wcnt++;
        if (m1_Wready) rdycnt++;
        tests++;
        if ({m1_Bvalid, m0_Bvalid, grant} !== 3'b101) begin
            fails++; $display("FAIL waw_b_route: m1_B=%b m0_B=%b grant=%b want 1 0 1", m1_Bvalid, m0_Bvalid, grant);
        end
        tests++;
        if (wcnt != 1 || awcnt != 1 || rdycnt != 1) begin
            fails++; $display("FAIL waw_single_w: w=%0d aw=%0d wready=%0d want 1 1 1", wcnt, awcnt, rdycnt);
        end
        @(posedge clk); #1;
        s_Bvalid = 1'b0; s_Wready = 1'b0; m1_AWvalid = 1'b0; m1_Wvalid = 1'b0;
        m1_Bready = 1'b0; m0_Bready = 1'b0;
    endtask

    task automatic test_round_robin();
        int c;
        m0_ARvalid = 1'b1; m0_ARdata = 32'h0000_0500; m0_Rready = 1'b1;
        m1_ARvalid = 1'b1; m1_ARdata = 32'h0000_0600; m1_Rready = 1'b1;
        for (int t = 0; t < 6; t++) begin
            c = 0;
            @(negedge clk);
            while (!busy && c < 4) begin
                @(negedge clk);
                c++;
            end
            tests++;
            if (busy !== 1'b1 || grant !== t[0] || s_ARdata !== (t[0] ? 32'h0000_0600 : 32'h0000_0500)) begin
                fails++; $display("FAIL rr_grant_%0d: busy=%b grant=%b ARdata=%h want grant %0d", t, busy, grant, s_ARdata, t % 2);
            end
            s_ARready = 1'b1;
            @(posedge clk); #1;
            s_ARready = 1'b0; s_Rvalid = 1'b1; s_Rdata = 32'hB000_0000 | 32'(t);
            @(negedge clk);
            tests++;
            if ({m0_Rvalid, m1_Rvalid} !== (t[0] ? 2'b01 : 2'b10) || s_ARvalid !== 1'b0) begin
                fails++; $display("FAIL rr_rvalid_%0d: m0=%b m1=%b ARvalid=%b", t, m0_Rvalid, m1_Rvalid, s_ARvalid);
            end
            @(posedge clk); #1;
            s_Rvalid = 1'b0;
        end
        m0_ARvalid = 1'b0; m1_ARvalid = 1'b0; m0_Rready = 1'b0; m1_Rready = 1'b0;
    endtask

    task automatic test_reset_mid_write();
        m1_AWvalid = 1'b1; m1_AWdata = 32'h0000_0800; m1_Wvalid = 1'b1; m1_Wdata = 32'h4444_4444;
        m1_Bready = 1'b1; s_AWready = 1'b1; s_Wready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        tests++;
        if ({busy, grant, s_AWvalid} !== 3'b111) begin
            fails++; $display("FAIL rstmid_grant: busy=%b grant=%b AWvalid=%b want 111", busy, grant, s_AWvalid);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        tests++;
        if (all_outs !== 187'd0) begin
            fails++; $display("FAIL rstmid_outputs: got %h want 0", all_outs);
        end
        clear_inputs();
        m0_ARvalid = 1'b1; m0_ARdata = 32'h0000_0900; m1_ARvalid = 1'b1; m1_ARdata = 32'h0000_0A00;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        tests++;
        if ({busy, grant} !== 2'b10 || s_ARdata !== 32'h0000_0900 || m1_ARready !== 1'b0) begin
            fails++; $display("FAIL rstmid_tie_m0: busy=%b grant=%b ARdata=%h want 1 0 900", busy, grant, s_ARdata);
        end
        do_reset();
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        int k;
        m0_ARvalid = 1'b1; m0_ARdata = 32'h0000_0700; m0_Rready = 1'b0;
        @(posedge clk); #1;
        k = 0;
        @(negedge clk);
        while (!m0_Rvalid && k < 20) begin
            @(negedge clk);
            k++;
        end
        tests++;
        if (k != 8 || m0_Rdata !== 32'hDEAD_BEEF || s_ARvalid !== 1'b0) begin
            fails++; $display("FAIL tmo_response: cycle=%0d Rdata=%h ARvalid=%b want 8 deadbeef 0", k, m0_Rdata, s_ARvalid);
        end
        @(posedge clk); #1;
        @(negedge clk);
        tests++;
        if ({m0_Rvalid, busy, timeout_err} !== 3'b110) begin
            fails++; $display("FAIL tmo_hold: Rvalid=%b busy=%b err=%b want 110", m0_Rvalid, busy, timeout_err);
        end
        m0_Rready = 1'b1;
        @(posedge clk); #1;
        m0_ARvalid = 1'b0; m0_Rready = 1'b0;
        @(negedge clk);
        tests++;
        if ({timeout_err, busy} !== 2'b10) begin
            fails++; $display("FAIL tmo_err_pulse: err=%b busy=%b want 10", timeout_err, busy);
        end
        @(negedge clk);
        tests++;
        if (timeout_err !== 1'b0) begin
            fails++; $display("FAIL tmo_err_clear: err=%b want 0", timeout_err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_read_m0();
        test_write_both();
        test_w_before_aw();
        test_round_robin();
        test_reset_mid_write();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axi_lite_arbiter.md
Name: axi_lite_arbiter

Overview:
Two-requester arbiter that shares one AXI4-Lite master port between requester 0 (mriscvcore MEMORY_INTERFACE) and requester 1 (debug/DMA agent).
- Grants the downstream port for one complete transaction at a time: AR+R or AW+W+B.
- Round-robin between requesters; write before read within one requester.
- Sits between the requesters and the system interconnect.
- Address buses keep the codebase's AWdata/ARdata naming.

Parameters:
- DATA_W, 32, data and address width.
- TIMEOUT_CYCLES, 255, watchdog limit (used only with the optional feature).
- CNT_W, 8, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- mN_AWdata, mN_ARdata, mN_Wdata (N=0,1)  in  DATA_W  requester N write addr / read addr / write data.
- mN_Wstrb  in  4  requester N byte strobes.
- mN_AWprot, mN_ARprot  in  3  requester N protection.
- mN_AWvalid, mN_Wvalid, mN_ARvalid, mN_Bready, mN_Rready  in  1  requester N handshakes.
- mN_AWready, mN_Wready, mN_ARready, mN_Bvalid, mN_Rvalid  out  1  requester N handshakes.
- mN_Rdata  out  DATA_W  requester N read data.
- s_AWdata, s_ARdata, s_Wdata  out  DATA_W  downstream addr/data.
- s_Wstrb  out  4  downstream strobes.
- s_AWprot, s_ARprot  out  3  downstream protection.
- s_AWvalid, s_Wvalid, s_ARvalid, s_Bready, s_Rready  out  1  downstream handshakes.
- s_AWready, s_Wready, s_ARready, s_Bvalid, s_Rvalid  in  1  downstream handshakes.
- s_Rdata  in  DATA_W  downstream read data.
- grant  out  1  index of the owning requester (valid when busy=1).
- busy  out  1  a transaction is in progress.

Behaviour:
- States: IDLE, WR, RD (registered; encoding defined in the package).
- Requests: reqN_wr = mN_AWvalid; reqN_rd = mN_ARvalid & ~mN_AWvalid (write wins within a requester).
- IDLE -> WR/RD when any request is present.
  - Only one requester requesting: it wins.
  - Both requesting: the requester != last_grant wins.
  - grant and busy are registered; the downstream channels open on the cycle after the request is sampled (1 cycle arbitration latency).
- WR:
  - s_AWvalid = mg_AWvalid & ~aw_done; s_Wvalid = mg_Wvalid & ~w_done (mg = granted requester).
  - AW and W may complete in either order or in the same cycle; aw_done and w_done are set on their respective handshakes.
  - s_Bready = mg_Bready.
  - B handshake -> IDLE; last_grant <= grant; aw_done and w_done cleared.
- RD:
  - s_ARvalid = mg_ARvalid & ~ar_done.
  - R handshake -> IDLE; last_grant updated.
- Routing:
  - Payload and valid signals are muxed combinationally from the granted requester to the downstream port.
  - Downstream ready/response signals are routed only to the granted requester.
  - All handshake outputs of the non-granted requester are 0.
  - In IDLE every downstream valid/ready and every requester ready/valid is 0; no combinational pass-through before grant.
- Downstream payloads (addr/data/strb/prot) are driven 0 when not granted.
- Back-to-back transactions: after completion the arbiter returns to IDLE for one cycle before re-arbitrating, which guarantees fairness under continuous load.
- Reset (async, mid-operation allowed):
  - State IDLE; busy=0; grant=0; last_grant=1, so requester 0 wins the first tie.
  - done flags cleared; all outputs 0.
  - Any in-flight transaction is abandoned; the system resets the slave concurrently.
- A requester dropping its valid mid-transaction is a protocol violation; the arbiter holds the grant until the response handshake completes.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- With the macro:
  - A CNT_W watchdog counter clears on every state entry and increments each cycle in WR/RD.
  - On reaching TIMEOUT_CYCLES, the arbiter returns a response to the granted requester: mg_Bvalid or mg_Rvalid = 1 with Rdata = 32'hDEAD_BEEF, held until the requester's ready.
  - It then goes to IDLE and pulses output timeout_err (1 cycle).
- Without the macro: no counter and no timeout_err port; a stalled slave blocks the arbiter indefinitely.

Decomposition:
- Package arb_pkg:
  - State encoding constants ST_IDLE=2'd0, ST_WR=2'd1, ST_RD=2'd2.
  - Requester index constants REQ_CORE=1'b0, REQ_AUX=1'b1.
  - Timeout response constant ARB_ERR_DATA=32'hDEAD_BEEF.
- One sub-module: arb_watchdog (counter plus expiry compare), instantiated only under ARB_TIMEOUT_EN.

Test Plan:
- Reset with both requesters idle -> all outputs 0, busy=0.
- m0 read of 0x100 only -> grant=0, s_ARdata=0x100 one cycle later; slave returns 0xCAFE0001; m0_Rdata=0xCAFE0001; IDLE after the R handshake.
- m0 and m1 both write in the same cycle after reset -> m0 served first (B completes), then m1 (grant=1); m1 sees no ready while m0 is owner.
- m1 writes with W accepted 3 cycles before AW -> single s_Wvalid pulse, no duplicate W, B routed only to m1.
- Continuous m0+m1 reads for 6 transactions -> grant alternates 0,1,0,1,0,1.
- Async rst asserted mid-WR after the AW handshake -> immediate IDLE, outputs 0; next request from m1 still loses a tie to m0.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never responds to a read -> Rvalid with 0xDEADBEEF at cycle 8, timeout_err pulse, return to IDLE.
